// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_pkg: shared state encoding and counter widths for the systolic skew feeder.
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, FULL, FEED, FLUSH} state_e;
    localparam int N_DEF = 4;
    localparam int STEP_W = $clog2(2 * N_DEF - 1);
    localparam int LD_W = $clog2(N_DEF);
    function automatic int step_w(input int n);
        return $clog2(2 * n - 1);
    endfunction
    function automatic int ld_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/systolic_skew_feeder_skew_lane_mux.sv
// skew_lane_mux: picks lane L's element for the current step, or zero outside its skew window.
module skew_lane_mux import systolic_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    parameter int L = 0
) (
    input  logic [N*N*WIDTH-1:0] mem_i,
    input  logic [step_w(N)-1:0] step_i,
    output logic [WIDTH-1:0]     lane_o
);
    localparam int SW = step_w(N);
    logic [SW-1:0] d;
    logic [SW-1:0] k;
    logic ok;
    always_comb begin
        d = step_i - SW'(L);
        ok = (step_i >= SW'(L)) && (d < SW'(N));
        k = ok ? d : '0;
        lane_o = ok ? mem_i[(int'(k) * N + L) * WIDTH +: WIDTH] : '0;
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers an NxN operand matrix and streams it diagonally skewed,
// followed by a zero flush, into one edge of the systolic array.
module systolic_skew_feeder import systolic_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int N = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               start,
    output logic               busy,
    output logic               out_valid,
    output logic [N*WIDTH-1:0] out_data,
    output logic               done
);
    localparam int SW = step_w(N);
    localparam int LW = ld_w(N);
    state_e state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [LW-1:0] ld_cnt_q, ld_cnt_d;
    logic [N*N*WIDTH-1:0] mem_q;
    logic [N*WIDTH-1:0] lanes;
    logic load;
    assign in_ready = state_q == IDLE;
    assign load = in_valid && in_ready;
    // Next-state values also drive the lane muxes so the registered outputs line up with state.
    always_comb begin
        state_d = state_q;
        step_d = step_q;
        ld_cnt_d = ld_cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                ld_cnt_d = (ld_cnt_q == LW'(N - 1)) ? '0 : ld_cnt_q + 1'b1;
                state_d = (ld_cnt_q == LW'(N - 1)) ? FULL : IDLE;
            end
            FULL: if (start) begin
                state_d = FEED;
                step_d = '0;
            end
            FEED: begin
                state_d = (step_q == SW'(2 * N - 2)) ? FLUSH : FEED;
                step_d = (step_q == SW'(2 * N - 2)) ? '0 : step_q + 1'b1;
            end
            default: begin
                state_d = (step_q == SW'(N - 2)) ? IDLE : FLUSH;
                step_d = (step_q == SW'(N - 2)) ? '0 : step_q + 1'b1;
            end
        endcase
    end
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane_mux #(.WIDTH(WIDTH), .N(N), .L(i)) u_mux (
            .mem_i (mem_q),
            .step_i(step_d),
            .lane_o(lanes[i*WIDTH +: WIDTH])
        );
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            step_q <= '0;
            ld_cnt_q <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q <= step_d;
            ld_cnt_q <= ld_cnt_d;
            out_data <= (state_d == FEED) ? lanes : '0;
            out_valid <= (state_d == FEED) || (state_d == FLUSH);
            busy <= (state_d == FEED) || (state_d == FLUSH);
            done <= (state_q == FLUSH) && (state_d == IDLE);
        end
    end
    // The operand buffer is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (load) mem_q[int'(ld_cnt_q) * N * WIDTH +: N * WIDTH] <= in_data;
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed checks of load, skewed streaming, flush, reset abort and a 4x4 array integration.
module tb_systolic_skew_feeder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic [63:0] in_data_a = '0, in_data_b = '0;
    logic in_ready_a, busy_a, out_valid_a, done_a;
    logic in_ready_b, busy_b, out_valid_b, done_b;
    logic [63:0] out_data_a, out_data_b;
    logic [15:0] ma[4][4], mb[4][4];
    logic [15:0] ar[4][4], br[4][4], z[4][4];
    int n_cmp = 0, n_fail = 0;

    always #5 clock = ~clock;

    systolic_skew_feeder #(.WIDTH(16), .N(4)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data_a),
        .start(start), .busy(busy_a), .out_valid(out_valid_a), .out_data(out_data_a), .done(done_a)
    );
    systolic_skew_feeder #(.WIDTH(16), .N(4)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data_b),
        .start(start), .busy(busy_b), .out_valid(out_valid_b), .out_data(out_data_b), .done(done_b)
    );

    // Reference 4x4 output-stationary grid: A flows east, B flows south, one register per hop.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic [15:0] av, bv;
                if (j == 0) av = out_data_a[i*16 +: 16];
                else av = ar[i][j-1];
                if (i == 0) bv = out_data_b[j*16 +: 16];
                else bv = br[i-1][j];
                ar[i][j] <= av;
                br[i][j] <= bv;
                z[i][j] <= clr ? 16'h0 : z[i][j] + av * bv;
            end
        end
    end

    function automatic logic [15:0] elem(input int r, input int c, input logic [15:0] m);
        return (16'h0100 * r[15:0] + c[15:0]) ^ m;
    endfunction

    function automatic logic [63:0] exp_step(input int t, input logic [15:0] m);
        logic [63:0] v = '0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i <= 3) v[i*16 +: 16] = elem(i, t - i, m);
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mat(input logic [15:0] m);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < 4; i++) in_data_a[i*16 +: 16] = elem(i, k, m);
            in_data_b = in_data_a;
            tick();
        end
        n_cmp++;
        if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop got=%b want=0", in_ready_a); end
        in_data_a = '1;
        in_data_b = '1;
        tick();
        tick();
        n_cmp++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL full_hold ready=%b busy=%b want 0/0", in_ready_a, busy_a);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({in_ready_a, busy_a, out_valid_a, done_a} !== 4'b1000 || out_data_a !== 64'h0) begin
            n_fail++; $display("FAIL reset_state rdy/busy/vld/done=%b data=%h want 1000/0", {in_ready_a, busy_a, out_valid_a, done_a}, out_data_a);
        end
    endtask

    task automatic test_idle_start();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (busy_a !== 1'b0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL idle_start busy=%b vld=%b rdy=%b want 0/0/1", busy_a, out_valid_a, in_ready_a);
        end
    endtask

    task automatic test_stream(input logic [15:0] m, input bit poke);
        int vcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            n_cmp++;
            if (out_data_a !== exp_step(t, m) || out_valid_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
                n_fail++; $display("FAIL stream_step%0d data=%h vld=%b busy=%b done=%b want %h/1/1/0", t, out_data_a, out_valid_a, busy_a, done_a, exp_step(t, m));
            end
            if (out_valid_a) vcnt++;
            if (m == 16'h0 && t == 1) begin
                n_cmp++;
                if (out_data_a !== 64'h0000_0000_0100_0001) begin n_fail++; $display("FAIL step1_const got=%h want 0000000001000001", out_data_a); end
            end
            if (m == 16'h0 && t == 3) begin
                n_cmp++;
                if (out_data_a !== 64'h0300_0201_0102_0003) begin n_fail++; $display("FAIL step3_const got=%h want 0300020101020003", out_data_a); end
            end
            if (m == 16'h0 && t == 6) begin
                n_cmp++;
                if (out_data_a !== 64'h0303_0000_0000_0000) begin n_fail++; $display("FAIL step6_const got=%h want 0303000000000000", out_data_a); end
            end
            if (poke && t == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if (vcnt != 10) begin n_fail++; $display("FAIL valid_count got=%0d want 10", vcnt); end
        n_cmp++;
        if (done_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== 64'h0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL done_cycle done=%b vld=%b data=%h rdy=%b busy=%b want 1/0/0/1/0", done_a, out_valid_a, out_data_a, in_ready_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        load_mat(16'hA5A5);
        test_stream(16'hA5A5, 1'b1);
        tick();
        n_cmp++;
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse got=%b want 0", done_a); end
    endtask

    task automatic test_reset_abort();
        bit seen = 1'b0;
        load_mat(16'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        n_cmp++;
        if (out_data_a !== exp_step(4, 16'h0)) begin n_fail++; $display("FAIL abort_step4 got=%h want %h", out_data_a, exp_step(4, 16'h0)); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out_valid_a !== 1'b0 || out_data_a !== 64'h0 || in_ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL abort_state vld=%b data=%h rdy=%b busy=%b done=%b want 0/0/1/0/0", out_valid_a, out_data_a, in_ready_a, busy_a, done_a);
        end
        for (int c = 0; c < 15; c++) begin
            if (done_a) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b want 0", seen); end
    endtask

    task automatic test_integration();
        int c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 16'($urandom);
                mb[i][j] = 16'($urandom);
            end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                in_data_a[i*16 +: 16] = ma[i][k];
                in_data_b[i*16 +: 16] = mb[k][i];
            end
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done_a && c < 20) begin
            tick();
            c++;
        end
        n_cmp++;
        if (done_a !== 1'b1 || done_b !== 1'b1 || c != 10) begin
            n_fail++; $display("FAIL int_done a=%b b=%b cycles=%0d want 1/1/10", done_a, done_b, c);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [15:0] e = '0;
                for (int k = 0; k < 4; k++) e = e + ma[i][k] * mb[k][j];
                n_cmp++;
                if (z[i][j] !== e) begin n_fail++; $display("FAIL int_z%0d%0d got=%h want %h", i, j, z[i][j], e); end
            end
    endtask

    initial begin
        test_reset();
        test_idle_start();
        load_mat(16'h0);
        test_stream(16'h0, 1'b0);
        test_back_to_back();
        test_reset_abort();
        test_integration();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder for the N×N systolic multiply array. It buffers one N×N operand matrix loaded one vector per beat, then streams it into one edge of the array with the diagonal skew the array needs. Lane i is delayed i cycles and zero-padded, followed by a zero flush long enough for the last product to reach the far corner cell. Two instances are used, one for A on the west edge and one for B on the north edge, started together.

## Interface
Parameters:
- WIDTH, 16, element width; must match the array cell WIDTH.
- N, 4, array dimension and lane count; N ≥ 2.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  load beat offered.
- in_ready  out  1  feeder accepts a load beat (high only in IDLE).
- in_data  in  N*WIDTH  load vector; lane i is bits [i*WIDTH +: WIDTH]. For A, beat k carries column k (lane i = a[i][k]). For B, beat k carries row k (lane j = b[k][j]).
- start  in  1  begin streaming; honoured only in FULL.
- busy  out  1  high in FEED and FLUSH.
- out_valid  out  1  high on every cycle out_data drives array input (FEED and FLUSH).
- out_data  out  N*WIDTH  registered skewed lanes to the array edge, same lane packing as in_data.
- done  out  1  one-cycle pulse after the last flush cycle.

## Operation
- States: IDLE → FULL → FEED → FLUSH → IDLE.
- IDLE: in_ready=1. Each in_valid&in_ready beat writes in_data into buffer slot ld_cnt, then increments ld_cnt. On the beat with ld_cnt=N-1, go to FULL and reset ld_cnt to 0.
- FULL: in_ready=0 and in_valid is ignored. On start=1, go to FEED with step=0.
- FEED: lasts 2N-1 cycles, steps t = 0..2N-2. Lane i outputs buf[t-i][i] when 0 ≤ t-i ≤ N-1, and 0 otherwise. After t=2N-2, go to FLUSH.
- FLUSH: lasts N-1 cycles. All lanes are 0 and out_valid=1. After the last FLUSH cycle, go to IDLE; done=1 in that first IDLE cycle.
- start is ignored in IDLE, FEED and FLUSH. in_valid is ignored outside IDLE.
- No arithmetic is performed. Elements pass through bit-exact. The zero pad is all-zero WIDTH bits, so the cell's accumulator is not disturbed.
- Buffer contents are not cleared by reset or on completion. They are overwritten by the next load.

## Timing
- Reset, sampled at posedge: state=IDLE, ld_cnt=0, step=0, out_data=0, out_valid=0, busy=0, done=0. in_ready=1 in the cycle after reset deasserts.
- Reset asserted mid-LOAD, FEED or FLUSH aborts immediately with the values above. No done pulse is produced.
- out_data, out_valid, busy and done are registered. in_ready is decoded from state.
- Latency from start:
  - Posedge where start is sampled in FULL = edge 0.
  - Step-0 lane data is visible after edge 0.
  - Step t is visible after edge t.
  - out_valid is high for exactly 3N-2 consecutive cycles.
  - done is high in the cycle after the last out_valid cycle. out_valid=0 and out_data=0 in that cycle.
- For two instances started on the same edge, the last nonzero pair enters cell (N-1,N-1) at step 3N-3, which is the final FLUSH cycle. The array result is valid when done is high.
- The last load beat and start cannot coincide, because start is ignored until FULL. The minimum gap is one cycle.
- Back-to-back: a new load may begin in the done cycle, since state is IDLE and in_ready=1.

## Structure
- Shared package systolic_pkg holds:
  - the state enum (IDLE, FULL, FEED, FLUSH);
  - the localparam step-count width $clog2(2N-1) and load-count width $clog2(N).
- The buffer is an N×N array of WIDTH registers inside the block. No RAM macro is used.
- One natural sub-module: skew_lane_mux. It takes the buffer and the step and produces one lane's element with zero-pad select. It is instantiated N times with a lane-index parameter.

## Test plan
N=4, WIDTH=16, element a[r][c] = 16'h0100*r + c, loaded as columns.
- Reset then 4 load beats → in_ready drops after beat 4, state FULL. in_valid held high afterwards is not accepted.
- start → step 0: lanes = {0,0,0,a00}, lane 0 first. Step 3: lane i = a[i][3-i] (0x0003, 0x0102, 0x0201, 0x0300). Step 6: only lane 3 = 0x0303.
- Count out_valid: exactly 10 cycles. The last 3 carry all-zero lanes. done pulses once, on cycle 11 after the start edge.
- Assert reset at step 4 → the next cycle shows out_valid=0, out_data=0, in_ready=1, and no done pulse ever appears.
- start pulsed in IDLE and during FEED → ignored. Step sequence and done timing are unchanged.
- Integration: two feeders (A=columns, B=rows, random 16-bit) driving a 4×4 grid of array cells, started together. When done is high, every cell z equals (A×B)[i][j] mod 2^16.
